garage_door_ctrl: RTL and testbench

Parametrised next-generation garage door controller: a single-door Moore FSM that drives the up and down motor outputs from a push-button and two limit switches. It adds four things a basic three-state controller lacks: edge-triggered activation, stop/reverse mid-travel, obstruction auto-reverse, and a configurable auto-close timer with travel-timeout fault detection. It sits between debounced door sensors/button and the motor driver.

---
 rtl/garage_door_ctrl_pkg.sv | 31 +++
 rtl/garage_door_ctrl_if.sv | 25 ++
 rtl/garage_door_ctrl_sat_counter.sv | 33 +++
 rtl/garage_door_ctrl.sv | 131 +++++++++++++
 tb/tb_garage_door_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/garage_door_ctrl_pkg.sv
// Purpose : shared state encoding, default parameters and counter sizing for the garage door controller.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Ports   : none (package garage_door_pkg).
package garage_door_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_MV_UP = 3'd1;
  localparam logic [2:0] ST_MV_DN = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    MV_UP = ST_MV_UP,
    MV_DN = ST_MV_DN,
    HOLD  = ST_HOLD,
    FAULT = ST_FAULT
  } state_t;

  localparam int DEF_AUTO_CLOSE_CYC = 1000;
  localparam int DEF_TIMEOUT_CYC    = 5000;

  // Bits needed to hold 0..n, never less than one.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/garage_door_ctrl_if.sv
// Purpose : groups door sensors, button and motor/fault outputs into one bundle.
// Latency : n/a (wiring only).
// Backpressure: none; all signals are plain levels.
// Ports   : master drives activate/UP_Max/DN_Max/obstruct/fault_clr and observes UP_M/DN_M/fault;
//           slave is the controller side.
interface garage_door_ctrl_if;
  logic activate;
  logic UP_Max;
  logic DN_Max;
  logic obstruct;
  logic fault_clr;
  logic UP_M;
  logic DN_M;
  logic fault;

  modport master (
    output activate, UP_Max, DN_Max, obstruct, fault_clr,
    input  UP_M, DN_M, fault
  );

  modport slave (
    input  activate, UP_Max, DN_Max, obstruct, fault_clr,
    output UP_M, DN_M, fault
  );
endinterface

// File: rtl/garage_door_ctrl_sat_counter.sv
// Purpose : up-counter that saturates at all-ones and flags a terminal count.
// Latency : count updates on the clock edge; tc is combinational from the count.
// Backpressure: none.
// Ports   : clk, rst_n (async active-low), clr (sync clear, wins over en), en (increment), tc (cnt == TC).
module gdc_sat_counter #(
  parameter int W  = 4,
  parameter int TC = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] TC_V    = W'(TC);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == TC_V);

endmodule

// File: rtl/garage_door_ctrl.sv
// Purpose : single-door Moore controller: edge-triggered button, stop/reverse, obstruction reverse,
//           auto-close timer and travel-timeout fault.
// Latency : one clock edge from sampled input to motor/fault output; reset clears outputs asynchronously.
// Backpressure: none; inputs are sampled every cycle.
// Ports   : CLK, RST (async active-low), io (slave: activate, UP_Max, DN_Max, obstruct, fault_clr -> UP_M, DN_M, fault).
module garage_door_ctrl
  import garage_door_pkg::*;
#(
  parameter int AUTO_CLOSE_CYC = DEF_AUTO_CLOSE_CYC,
  parameter int TIMEOUT_CYC    = DEF_TIMEOUT_CYC
) (
  input logic              CLK,
  input logic              RST,
  garage_door_ctrl_if.slave io
);

  localparam int   AC_W  = cnt_width(AUTO_CLOSE_CYC);
  localparam int   TR_W  = cnt_width(TIMEOUT_CYC);
  localparam int   AC_TC = (AUTO_CLOSE_CYC > 0) ? AUTO_CLOSE_CYC - 1 : 0;
  localparam int   TR_TC = (TIMEOUT_CYC > 1) ? TIMEOUT_CYC - 1 : 0;
  localparam logic AC_EN = (AUTO_CLOSE_CYC > 0);

  state_t state, next_state;
  logic   last_dir, next_dir;
  logic   act_q;
  logic   armed;
  logic   act_p;
  logic   ac_cond, ac_inc, ac_tc;
  logic   travel, tr_clr, tr_tc;

  // act_q alone would see a press if activate is already high when reset
  // releases; armed holds off edge detection until activate is sampled low once.
  assign act_p = io.activate & ~act_q & armed;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      last_dir <= 1'b0;
      act_q    <= 1'b0;
      armed    <= 1'b0;
    end else begin
      state    <= next_state;
      last_dir <= next_dir;
      act_q    <= io.activate;
      armed    <= armed | ~io.activate;
    end
  end

  assign travel  = (state == MV_UP) || (state == MV_DN);
  assign ac_cond = AC_EN && (state == IDLE) && io.UP_Max && !io.obstruct;

  always_comb begin
    next_state = state;
    next_dir   = last_dir;
    // Both limits at once means a broken sensor; this outranks everything.
    if (io.UP_Max && io.DN_Max && (state != FAULT)) begin
      next_state = FAULT;
    end else begin
      case (state)
        IDLE: begin
          if (act_p) begin
            // Position unknown (no limit) opens first.
            if (io.DN_Max)      next_state = MV_UP;
            else if (io.UP_Max) next_state = MV_DN;
            else                next_state = MV_UP;
          end else if (ac_cond && ac_tc) begin
            next_state = MV_DN;
          end
        end
        MV_UP: begin
          if (io.UP_Max) begin
            next_state = IDLE;
          end else if (act_p) begin
            next_state = HOLD;
            next_dir   = 1'b1;
          end else if (tr_tc) begin
            next_state = FAULT;
          end
        end
        MV_DN: begin
          if (io.DN_Max) begin
            next_state = IDLE;
          end else if (io.obstruct) begin
            next_state = MV_UP;
          end else if (act_p) begin
            next_state = HOLD;
            next_dir   = 1'b0;
          end else if (tr_tc) begin
            next_state = FAULT;
          end
        end
        HOLD: begin
          if (act_p) next_state = last_dir ? MV_DN : MV_UP;
        end
        FAULT: begin
          if (io.fault_clr) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Counting stops (and clears) the moment IDLE is left, so a stale run
  // can never carry into a later open period.
  assign ac_inc = ac_cond && (next_state == IDLE);

  gdc_sat_counter #(.W(AC_W), .TC(AC_TC)) u_ac_cnt (
    .clk  (CLK),
    .rst_n(RST),
    .clr  (~ac_inc),
    .en   (ac_inc),
    .tc   (ac_tc)
  );

  // Any state change clears the travel count, which covers every entry into
  // a travel state including the direct MV_DN -> MV_UP reversal.
  assign tr_clr = (next_state != state);

  gdc_sat_counter #(.W(TR_W), .TC(TR_TC)) u_tr_cnt (
    .clk  (CLK),
    .rst_n(RST),
    .clr  (tr_clr),
    .en   (travel),
    .tc   (tr_tc)
  );

  assign io.UP_M  = (state == MV_UP);
  assign io.DN_M  = (state == MV_DN);
  assign io.fault = (state == FAULT);

endmodule

// File: tb/tb_garage_door_ctrl.sv
// Purpose : self-checking bench for garage_door_ctrl (AUTO_CLOSE_CYC=8, TIMEOUT_CYC=16, 20 ns clock).
// Latency : n/a.
// Backpressure: n/a.
module tb_garage_door_ctrl;

  localparam int AC = 8;
  localparam int TO = 16;

  localparam int M_IDLE  = 0;
  localparam int M_UP    = 1;
  localparam int M_DN    = 2;
  localparam int M_HOLD  = 3;
  localparam int M_FAULT = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  garage_door_ctrl_if io();

  garage_door_ctrl #(.AUTO_CLOSE_CYC(AC), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK),
    .RST(RST),
    .io (io)
  );

  always #10 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Door position in words: which phase it is in, how many consecutive
  // qualifying open-idle cycles have elapsed, how many cycles the current
  // travel leg has lasted, and whether the last sampled button level was high
  // (treated as high straight after reset so a held button is not a press).
  int m_st    = M_IDLE;
  int m_run   = 0;
  int m_trav  = 0;
  bit m_dir   = 1'b0;
  bit m_prevh = 1'b1;

  always @(posedge CLK or negedge RST) begin : model
    int st, run, trav;
    bit dir, press, qual, up, dn;
    if (!RST) begin
      m_st    <= M_IDLE;
      m_run   <= 0;
      m_trav  <= 0;
      m_dir   <= 1'b0;
      m_prevh <= 1'b1;
    end else begin
      up    = io.UP_Max;
      dn    = io.DN_Max;
      press = io.activate && !m_prevh;
      qual  = (m_st == M_IDLE) && up && !io.obstruct;
      st    = m_st;
      dir   = m_dir;
      trav  = m_trav;
      if (m_st == M_UP || m_st == M_DN) trav = trav + 1;
      if (up && dn && m_st != M_FAULT) begin
        st = M_FAULT;
      end else if (m_st == M_IDLE) begin
        if (press) st = dn ? M_UP : (up ? M_DN : M_UP);
        else if (qual && (m_run + 1 == AC)) st = M_DN;
      end else if (m_st == M_UP) begin
        if (up) st = M_IDLE;
        else if (press) begin st = M_HOLD; dir = 1'b1; end
        else if (trav == TO) st = M_FAULT;
      end else if (m_st == M_DN) begin
        if (dn) st = M_IDLE;
        else if (io.obstruct) st = M_UP;
        else if (press) begin st = M_HOLD; dir = 1'b0; end
        else if (trav == TO) st = M_FAULT;
      end else if (m_st == M_HOLD) begin
        if (press) st = dir ? M_DN : M_UP;
      end else begin
        if (io.fault_clr) st = M_IDLE;
      end
      if (st != m_st) trav = 0;
      run = (qual && st == M_IDLE) ? m_run + 1 : 0;
      m_st    <= st;
      m_run   <= run;
      m_trav  <= trav;
      m_dir   <= dir;
      m_prevh <= io.activate;
    end
  end

  // Every cycle, away from the active edge, outputs must match the model.
  always @(negedge CLK) begin
    chk("model_up_m",  int'(io.UP_M),  int'(m_st == M_UP));
    chk("model_dn_m",  int'(io.DN_M),  int'(m_st == M_DN));
    chk("model_fault", int'(io.fault), int'(m_st == M_FAULT));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #5;
  endtask

  // Ticks until the chosen output goes high; returns limit if it never does.
  task automatic cycles_until(input int which, input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (n < limit && !((which == 0) ? io.DN_M : io.fault));
  endtask

  int n;

  initial begin
    io.activate  = 1'b0;
    io.UP_Max    = 1'b0;
    io.DN_Max    = 1'b0;
    io.obstruct  = 1'b0;
    io.fault_clr = 1'b0;
    #1 RST = 1'b0;
    tick(); tick();
    chk("rst_up_m",  int'(io.UP_M),  0);
    chk("rst_dn_m",  int'(io.DN_M),  0);
    chk("rst_fault", int'(io.fault), 0);
    RST = 1'b1;
    tick();

    // Open from closed, then hit the open limit.
    io.DN_Max = 1'b1; io.activate = 1'b1;
    tick();
    chk("open_up_m", int'(io.UP_M), 1);
    io.activate = 1'b0; io.DN_Max = 1'b0;
    repeat (5) tick();
    io.UP_Max = 1'b1;
    tick();
    chk("open_stop_up_m", int'(io.UP_M), 0);
    chk("open_stop_dn_m", int'(io.DN_M), 0);

    // Auto-close with an obstruction blip restarting the count.
    repeat (4) tick();
    io.obstruct = 1'b1;
    tick();
    io.obstruct = 1'b0;
    cycles_until(0, 30, n);
    chk("ac_restart_cycles", n, AC);
    io.UP_Max = 1'b0;
    tick(); tick();
    io.DN_Max = 1'b1;
    tick();
    chk("closed_dn_m", int'(io.DN_M), 0);
    io.DN_Max = 1'b0; io.UP_Max = 1'b1;
    cycles_until(0, 30, n);
    chk("ac_plain_cycles", n, AC);

    // Obstruction together with a press while closing reverses.
    io.UP_Max = 1'b0;
    tick();
    io.obstruct = 1'b1; io.activate = 1'b1;
    tick();
    chk("obst_up_m", int'(io.UP_M), 1);
    chk("obst_dn_m", int'(io.DN_M), 0);
    io.obstruct = 1'b0; io.activate = 1'b0;
    tick();

    // Stop mid-travel, then reverse; a held button acts once.
    io.activate = 1'b1;
    tick();
    chk("hold_up_m", int'(io.UP_M), 0);
    chk("hold_dn_m", int'(io.DN_M), 0);
    io.activate = 1'b0;
    repeat (3) tick();
    chk("hold_stays", int'(io.UP_M | io.DN_M), 0);
    io.activate = 1'b1;
    tick();
    chk("hold_rev_dn_m", int'(io.DN_M), 1);
    n = 0;
    repeat (10) begin
      tick();
      n += int'(io.DN_M);
    end
    chk("held_single_press", n, 10);
    io.activate = 1'b0; io.DN_Max = 1'b1;
    tick();
    chk("closed2_dn_m", int'(io.DN_M), 0);
    io.DN_Max = 1'b0;
    tick();

    // Travel timeout, fault handling, and the both-limits rule.
    io.activate = 1'b1;
    tick();
    chk("to_start_up_m", int'(io.UP_M), 1);
    io.activate = 1'b0;
    cycles_until(1, 40, n);
    chk("timeout_cycles", n, TO);
    chk("fault_up_m", int'(io.UP_M), 0);
    io.activate = 1'b1; tick();
    io.activate = 1'b0; tick();
    chk("fault_ignores_act", int'(io.fault), 1);
    chk("fault_motor_off", int'(io.UP_M | io.DN_M), 0);
    io.fault_clr = 1'b1;
    tick();
    chk("fault_cleared", int'(io.fault), 0);
    io.fault_clr = 1'b0;
    io.UP_Max = 1'b1; io.DN_Max = 1'b1;
    tick();
    chk("both_limits_fault", int'(io.fault), 1);
    io.UP_Max = 1'b0; io.DN_Max = 1'b0; io.fault_clr = 1'b1;
    tick();
    io.fault_clr = 1'b0;
    chk("fault_cleared2", int'(io.fault), 0);

    // Asynchronous reset while closing; held button must not start motion.
    io.UP_Max = 1'b1; io.activate = 1'b1;
    tick();
    chk("pre_rst_dn_m", int'(io.DN_M), 1);
    io.activate = 1'b0; io.UP_Max = 1'b0;
    tick();
    RST = 1'b0;
    #2;
    chk("async_rst_dn_m", int'(io.DN_M), 0);
    io.activate = 1'b1; io.DN_Max = 1'b1;
    tick();
    RST = 1'b1;
    repeat (3) tick();
    chk("no_spurious_up_m", int'(io.UP_M), 0);
    chk("no_spurious_dn_m", int'(io.DN_M), 0);
    io.activate = 1'b0;
    tick();
    io.activate = 1'b1;
    tick();
    chk("rearm_up_m", int'(io.UP_M), 1);
    io.activate = 1'b0; io.DN_Max = 1'b0;

    // Randomised phase in blocks with different limit-switch densities.
    for (int blk = 0; blk < 12; blk++) begin
      int lim_rate;
      lim_rate = (blk % 3 == 0) ? 5 : ((blk % 3 == 1) ? 40 : 12);
      repeat (250) begin
        io.UP_Max    = ($urandom_range(0, lim_rate - 1) == 0);
        io.DN_Max    = ($urandom_range(0, lim_rate - 1) == 0);
        io.obstruct  = ($urandom_range(0, 7) == 0);
        io.fault_clr = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 3) == 0) io.activate = ~io.activate;
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
